// File: rtl/sdcard_pkg.sv
// Shared constants and types for the SD-card sector loader.
package sdcard_pkg;

    typedef logic [1:0] sd_cmd_t;

    localparam sd_cmd_t SdCmdNone       = 2'd0;
    localparam sd_cmd_t SdCmdReadSector = 2'd1;
    localparam sd_cmd_t SdCmdNextByte   = 2'd2;

    localparam int unsigned SectorBytes = 512;
    localparam int unsigned WordBytes   = 4;

    typedef enum logic [2:0] {
        Idle,
        WaitCard,
        IssueRead,
        WaitAck,
        WaitRead,
        Fetch,
        Write,
        Done
    } sdcard_loader_state_e;

endpackage

// File: rtl/byte_packer.sv
// Shifts bytes in from the top so the first byte ends up in bits [7:0] after four shifts.
module byte_packer (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        shift_i,
    input  logic        clear_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        full_o
);

    logic [31:0] word_q;
    logic [2:0]  cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else if (clear_i) begin
            cnt_q  <= '0;
        end else if (shift_i) begin
            word_q <= {byte_i, word_q[31:8]};
            if (cnt_q != 3'd4) begin
                cnt_q <= cnt_q + 3'd1;
            end
        end
    end

    assign word_o = word_q;
    assign full_o = (cnt_q == 3'd4);

endmodule

// File: rtl/sdcard_loader.sv
// Multi-sector copy engine: reads consecutive SD sectors through the sector buffer byte port
// and writes them to RAM as little-endian 32-bit words over a ready/valid port.
module sdcard_loader
    import sdcard_pkg::*;
#(
    parameter int unsigned CountBitWidth = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic [31:0]              sector_i,
    input  logic [CountBitWidth-1:0] count_i,
    input  logic [31:0]              dest_address_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [1:0]               sd_cmd_o,
    output logic [31:0]              sd_sector_o,
    input  logic [7:0]               sd_data_i,
    input  logic                     sd_busy_i,
    output logic [31:0]              mem_address_o,
    output logic [31:0]              mem_data_o,
    output logic                     mem_write_o,
    input  logic                     mem_ready_i
);

    localparam logic [9:0] SectorEnd = 10'(SectorBytes);
    localparam logic [9:0] WordStep  = 10'(WordBytes);

    sdcard_loader_state_e state_q, state_d;

    logic [31:0]              sector_q, sector_d;
    logic [CountBitWidth-1:0] count_q, count_d;
    logic [31:0]              addr_q, addr_d;
    logic [9:0]               byte_cnt_q, byte_cnt_d;
    logic [2:0]               req_cnt_q, req_cnt_d;
    logic                     cap_en_q;

    sd_cmd_t sd_cmd_q, sd_cmd_d;
    logic    busy_q, busy_d;
    logic    done_q, done_d;
    logic    mem_write_q, mem_write_d;

    logic [31:0] pack_word;
    logic        pack_full;
    logic        word_accept;
    logic [9:0]  byte_cnt_inc;
    logic        sector_end;
    logic        last_sector;

    assign word_accept  = (state_q == Write) && mem_ready_i && pack_full;
    assign byte_cnt_inc = byte_cnt_q + WordStep;
    assign sector_end   = (byte_cnt_inc == SectorEnd);
    assign last_sector  = (count_q == CountBitWidth'(1));

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= Idle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            Idle: begin
                if (start_i) begin
                    state_d = (count_i == '0) ? Done : WaitCard;
                end
            end
            WaitCard:  if (!sd_busy_i) state_d = IssueRead;
            IssueRead: state_d = WaitAck;
            // Buffer raises busy one cycle after the read command, so skip a cycle blindly.
            WaitAck:   state_d = WaitRead;
            WaitRead:  if (!sd_busy_i) state_d = Fetch;
            Fetch:     if (req_cnt_q == 3'd4) state_d = Write;
            Write: begin
                if (word_accept) begin
                    if (!sector_end) begin
                        state_d = Fetch;
                    end else begin
                        state_d = last_sector ? Done : WaitCard;
                    end
                end
            end
            Done:      state_d = Idle;
            default:   state_d = Idle;
        endcase
    end

    // Datapath next-state
    always_comb begin
        sector_d   = sector_q;
        count_d    = count_q;
        addr_d     = addr_q;
        byte_cnt_d = byte_cnt_q;
        if (state_q == Idle && start_i) begin
            sector_d = sector_i;
            count_d  = count_i;
            addr_d   = {dest_address_i[31:2], 2'b00};
        end
        if (state_q == WaitRead && !sd_busy_i) begin
            byte_cnt_d = '0;
        end
        if (word_accept) begin
            addr_d     = addr_q + 32'd4;
            byte_cnt_d = byte_cnt_inc;
            if (sector_end) begin
                sector_d = sector_q + 32'd1;
                count_d  = count_q - CountBitWidth'(1);
            end
        end
        // Commands issued so far for the word being fetched; restarts on every Fetch entry.
        if (state_q != Fetch) begin
            req_cnt_d = '0;
        end else if (req_cnt_q != 3'd4) begin
            req_cnt_d = req_cnt_q + 3'd1;
        end else begin
            req_cnt_d = req_cnt_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sector_q   <= '0;
            count_q    <= '0;
            addr_q     <= '0;
            byte_cnt_q <= '0;
            req_cnt_q  <= '0;
            cap_en_q   <= 1'b0;
        end else begin
            sector_q   <= sector_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            byte_cnt_q <= byte_cnt_d;
            req_cnt_q  <= req_cnt_d;
            cap_en_q   <= (sd_cmd_q == SdCmdNextByte);
        end
    end

    // Output logic, computed from the upcoming state so every output leaves a flop
    always_comb begin
        sd_cmd_d = SdCmdNone;
        if (state_d == IssueRead) begin
            sd_cmd_d = SdCmdReadSector;
        end else if (state_d == Fetch && req_cnt_d != 3'd4) begin
            sd_cmd_d = SdCmdNextByte;
        end
        busy_d      = (state_d != Idle);
        done_d      = (state_q == Done);
        mem_write_d = (state_d == Write);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sd_cmd_q    <= SdCmdNone;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            sd_cmd_q    <= sd_cmd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mem_write_q <= mem_write_d;
        end
    end

    byte_packer u_byte_packer (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .shift_i (cap_en_q),
        .clear_i (word_accept),
        .byte_i  (sd_data_i),
        .word_o  (pack_word),
        .full_o  (pack_full)
    );

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign sd_cmd_o      = sd_cmd_q;
    assign sd_sector_o   = sector_q;
    assign mem_address_o = addr_q;
    assign mem_data_o    = pack_word;
    assign mem_write_o   = mem_write_q;

endmodule

// File: tb/tb_sdcard_loader.sv
// Bench for sdcard_loader: behavioural sector buffer, random RAM back-pressure and a
// scoreboard of expected RAM writes derived directly from sector contents.
module tb_sdcard_loader;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [31:0] sector_i;
    logic [15:0] count_i;
    logic [31:0] dest_address_i;
    logic        busy_o;
    logic        done_o;
    logic [1:0]  sd_cmd_o;
    logic [31:0] sd_sector_o;
    logic [7:0]  sd_data_i;
    logic        sd_busy_i;
    logic [31:0] mem_address_o;
    logic [31:0] mem_data_o;
    logic        mem_write_o;
    logic        mem_ready_i;

    always #5 clk_i = ~clk_i;

    sdcard_loader #(.CountBitWidth(16)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .sector_i       (sector_i),
        .count_i        (count_i),
        .dest_address_i (dest_address_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .sd_cmd_o       (sd_cmd_o),
        .sd_sector_o    (sd_sector_o),
        .sd_data_i      (sd_data_i),
        .sd_busy_i      (sd_busy_i),
        .mem_address_o  (mem_address_o),
        .mem_data_o     (mem_data_o),
        .mem_write_o    (mem_write_o),
        .mem_ready_i    (mem_ready_i)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    int n_checks = 0;
    int n_errors = 0;

    wr_t         exp_q[$];
    logic [31:0] exp_sec_q[$];
    logic [31:0] mix = 0;
    int          ready_pct = 100;
    logic        init_busy = 1'b0;
    logic        buf_busy = 1'b0;
    int          done_cnt = 0;
    int          n_writes = 0;
    logic        first_taken = 1'b0;
    logic [31:0] first_addr, first_data, last_addr, last_data;

    assign sd_busy_i = buf_busy | init_busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Sector content seen by the loader: byte k of a sector, optionally skewed by sector number.
    function automatic logic [7:0] byte_of(input logic [31:0] sec, input int k);
        logic [31:0] t;
        t = 32'(k) + mix * sec;
        return t[7:0];
    endfunction

    // Sector buffer model: reacts to the command seen in the previous cycle.
    initial begin
        logic [1:0]  cmd_s;
        logic [31:0] sec_s;
        logic [31:0] buf_sec;
        int          buf_ptr;
        int          busy_left;
        sd_data_i = 8'h00;
        buf_sec   = 0;
        buf_ptr   = 0;
        busy_left = 0;
        forever begin
            @(negedge clk_i);
            cmd_s = sd_cmd_o;
            sec_s = sd_sector_o;
            @(posedge clk_i);
            #1;
            if (!rst_ni) begin
                buf_busy  = 1'b0;
                busy_left = 0;
                buf_ptr   = 0;
            end else begin
                if (busy_left > 0) begin
                    busy_left--;
                    if (busy_left == 0) buf_busy = 1'b0;
                end
                if (cmd_s == 2'd1) begin
                    buf_sec   = sec_s;
                    buf_ptr   = 0;
                    buf_busy  = 1'b1;
                    busy_left = $urandom_range(2, 12);
                end else if (cmd_s == 2'd2) begin
                    sd_data_i = byte_of(buf_sec, buf_ptr);
                    buf_ptr++;
                end
            end
        end
    end

    initial begin
        mem_ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            mem_ready_i = ($urandom_range(0, 99) < ready_pct);
        end
    end

    // Monitor: scoreboard of reads and writes, stall stability, done pulses.
    initial begin
        logic        stall_prev;
        logic [31:0] prev_addr, prev_data;
        wr_t         e;
        stall_prev = 1'b0;
        prev_addr  = 0;
        prev_data  = 0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                stall_prev = 1'b0;
            end else begin
                if (init_busy) check("cmd_during_card_busy", 32'(sd_cmd_o), 0);
                if (sd_cmd_o == 2'd1) begin
                    if (exp_sec_q.size() == 0) check("unexpected_read", 1, 0);
                    else check("read_sector", sd_sector_o, exp_sec_q.pop_front());
                end
                if (mem_write_o) begin
                    if (stall_prev) begin
                        check("stall_addr", mem_address_o, prev_addr);
                        check("stall_data", mem_data_o, prev_data);
                    end
                    if (mem_ready_i) begin
                        n_writes++;
                        if (!first_taken) begin
                            first_taken = 1'b1;
                            first_addr  = mem_address_o;
                            first_data  = mem_data_o;
                        end
                        last_addr = mem_address_o;
                        last_data = mem_data_o;
                        if (exp_q.size() == 0) begin
                            check("unexpected_write", mem_address_o, 32'hxxxx_xxxx);
                        end else begin
                            e = exp_q.pop_front();
                            check("write_addr", mem_address_o, e.addr);
                            check("write_data", mem_data_o, e.data);
                        end
                    end
                end
                stall_prev = mem_write_o && !mem_ready_i;
                prev_addr  = mem_address_o;
                prev_data  = mem_data_o;
                if (done_o) done_cnt++;
            end
        end
    end

    task automatic start_copy(input logic [31:0] sec, input int cnt, input logic [31:0] dest);
        wr_t         w;
        logic [31:0] s;
        for (int i = 0; i < cnt; i++) begin
            s = sec + 32'(i);
            exp_sec_q.push_back(s);
            for (int k = 0; k < 512; k += 4) begin
                w.addr = {dest[31:2], 2'b00} + 32'(i * 512 + k);
                w.data = {byte_of(s, k + 3), byte_of(s, k + 2), byte_of(s, k + 1), byte_of(s, k)};
                exp_q.push_back(w);
            end
        end
        first_taken = 1'b0;
        @(posedge clk_i);
        #1;
        sector_i       = sec;
        count_i        = 16'(cnt);
        dest_address_i = dest;
        start_i        = 1'b1;
        @(posedge clk_i);
        #1;
        start_i        = 1'b0;
        sector_i       = $urandom;
        count_i        = 16'($urandom_range(1, 9));
        dest_address_i = $urandom;
        check("busy_after_start", 32'(busy_o), 1);
    endtask

    task automatic run_copy(input logic [31:0] sec, input int cnt, input logic [31:0] dest,
                            input int hold, input bit poke);
        int d0, w0;
        d0 = done_cnt;
        w0 = n_writes;
        start_copy(sec, cnt, dest);
        for (int c = 0; c < 20000 && done_cnt == d0; c++) begin
            @(posedge clk_i);
            #1;
            if (c == hold) init_busy = 1'b0;
            if (poke && c == 200) start_i = 1'b1;
            if (poke && c == 201) start_i = 1'b0;
        end
        repeat (5) @(posedge clk_i);
        #1;
        check("done_pulses", done_cnt - d0, 1);
        check("write_count", n_writes - w0, cnt * 128);
        check("writes_left", exp_q.size(), 0);
        check("reads_left", exp_sec_q.size(), 0);
        check("busy_after_done", 32'(busy_o), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy_o), 0);
        check({tag, "_done"}, 32'(done_o), 0);
        check({tag, "_cmd"}, 32'(sd_cmd_o), 0);
        check({tag, "_sector"}, sd_sector_o, 0);
        check({tag, "_addr"}, mem_address_o, 0);
        check({tag, "_data"}, mem_data_o, 0);
        check({tag, "_write"}, 32'(mem_write_o), 0);
    endtask

    initial begin
        int d0, w0;
        rst_ni         = 1'b0;
        start_i        = 1'b0;
        sector_i       = 0;
        count_i        = 0;
        dest_address_i = 0;
        repeat (3) @(posedge clk_i);
        #2;
        check_idle_outputs("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Plain 0x00..0xFF sector at 0x100
        mix = 0;
        ready_pct = 100;
        run_copy(32'd5, 1, 32'h100, 0, 1'b0);
        check("t1_first_addr", first_addr, 32'h100);
        check("t1_first_data", first_data, 32'h0302_0100);
        check("t1_last_addr", last_addr, 32'h2FC);
        check("t1_last_data", last_data, 32'hFFFE_FDFC);

        // Sector number wraps, low address bits ignored
        mix = 3;
        run_copy(32'hFFFF_FFFF, 3, 32'h2003, 0, 1'b0);

        // RAM back-pressure
        ready_pct = 30;
        run_copy(32'h1234_0000, 2, 32'h8000_0000, 0, 1'b0);
        ready_pct = 100;

        // Card initialisation holds the buffer busy after reset
        @(negedge clk_i);
        rst_ni = 1'b0;
        init_busy = 1'b1;
        @(negedge clk_i);
        rst_ni = 1'b1;
        run_copy(32'd9, 1, 32'h4000, 1000, 1'b0);

        // count == 0
        d0 = done_cnt;
        w0 = n_writes;
        @(posedge clk_i);
        #1;
        sector_i = 32'd7;
        count_i  = 16'd0;
        start_i  = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        check("c0_busy", 32'(busy_o), 1);
        check("c0_done_early", 32'(done_o), 0);
        @(posedge clk_i);
        #1;
        check("c0_done", 32'(done_o), 1);
        check("c0_busy_dropped", 32'(busy_o), 0);
        @(posedge clk_i);
        #1;
        check("c0_done_one_cycle", 32'(done_o), 0);
        repeat (10) @(posedge clk_i);
        #1;
        check("c0_writes", n_writes - w0, 0);
        check("c0_done_pulses", done_cnt - d0, 1);

        // start_i during a copy must be ignored
        ready_pct = 50;
        run_copy(32'd100, 2, 32'h600, 0, 1'b1);
        ready_pct = 100;

        // Asynchronous reset mid-sector, then a fresh copy
        d0 = done_cnt;
        start_copy(32'd42, 2, 32'hA000);
        repeat (300) @(posedge clk_i);
        @(negedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        check_idle_outputs("midreset");
        exp_q.delete();
        exp_sec_q.delete();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (5) @(posedge clk_i);
        #1;
        check("midreset_no_done", done_cnt - d0, 0);
        mix = 5;
        run_copy(32'd77, 1, 32'hC00, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sdcard_loader.md
# sdcard_loader

Multi-sector copy engine downstream of the SD card sector-buffer block. On a start pulse it reads `count_i` consecutive 512-byte sectors through the buffer's `cmd_i`/`data_o` byte interface. It packs bytes little-endian into 32-bit words and writes them to RAM through a ready/valid write port. Used by the boot path to load a program image from SD card into RAM.

## Interface
- `CountBitWidth`, 16, width of sector count.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `start_i`  in  1  one-cycle request; sampled only in `Idle`.
- `sector_i`  in  32  first SD sector address.
- `count_i`  in  CountBitWidth  sectors to copy.
- `dest_address_i`  in  32  RAM byte address of first word; bits [1:0] ignored (treated as 0).
- `busy_o`  out  1  high from cycle after accepted start until `done_o`.
- `done_o`  out  1  one-cycle pulse when copy complete.
- `sd_cmd_o`  out  2  to sector buffer: 0 none, 1 read sector, 2 next byte.
- `sd_sector_o`  out  32  sector address to buffer; stable while busy.
- `sd_data_i`  in  8  byte from buffer; valid the cycle after `sd_cmd_o`=2.
- `sd_busy_i`  in  1  buffer busy (card init or sector read).
- `mem_address_o`  out  32  word-aligned RAM address.
- `mem_data_o`  out  32  word to write.
- `mem_write_o`  out  1  write valid; held until `mem_ready_i`.
- `mem_ready_i`  in  1  write accepted this cycle.

## Operation
- States: `Idle`, `WaitCard`, `IssueRead`, `WaitAck`, `WaitRead`, `Fetch`, `Write`, `Done`.
- `Idle`: on `start_i`, latch sector, count, address (bits [1:0] zeroed); if count=0 go `Done`, else `WaitCard`.
- `WaitCard`: stay while `sd_busy_i`; then `IssueRead`.
- `IssueRead`: drive `sd_cmd_o`=1 for exactly one cycle → `WaitAck`.
- `WaitAck`: one unconditional cycle (buffer raises busy registered) → `WaitRead`.
- `WaitRead`: stay while `sd_busy_i`; then clear byte counter (10-bit, 0..511) → `Fetch`.
- `Fetch`: drive `sd_cmd_o`=2 on 4 consecutive cycles; capture `sd_data_i` one cycle after each command; byte k of word goes to bits [8k+7:8k]. After 4th capture → `Write`.
- `Write`: assert `mem_write_o` with packed word; on `mem_ready_i`: address += 4, byte counter += 4. If counter reached 512: sector += 1, count −= 1; count now 0 → `Done`, else `WaitCard`. Otherwise → `Fetch`.
- `Done`: pulse `done_o`, drop `busy_o` → `Idle`.
- Arithmetic: sector and address wrap modulo 2^32; count never underflows (checked 0 at start).
- `start_i` while not `Idle` ignored. `sd_cmd_o`=0 in every state/cycle not listed above.

## Timing
- Reset values: `busy_o`=0, `done_o`=0, `sd_cmd_o`=0, `sd_sector_o`=0, `mem_address_o`=0, `mem_data_o`=0, `mem_write_o`=0; state `Idle`.
- Async reset mid-copy aborts immediately; no `done_o`. Bench resets sector buffer together.
- All outputs registered.
- Per word with `mem_ready_i` tied high: 4 fetch cycles + 1 capture cycle + 1 write cycle = 6 cycles; 768 cycles to drain a sector after buffer busy falls.
- `mem_address_o`/`mem_data_o` stable while `mem_write_o` high and `mem_ready_i` low.
- count=0: `done_o` two cycles after start, no SD or RAM activity.

## Structure
- Package `sdcard_pkg`: `SdCmdNone`=0, `SdCmdReadSector`=1, `SdCmdNextByte`=2, `SectorBytes`=512, state enum `sdcard_loader_state_e`.
- One sub-module, `byte_packer`: shift-in of 4 bytes into little-endian 32-bit word with `full` flag; the rest stays in the top module.

## Test plan
- Sector model holding bytes 0x00..0xFF repeating; start sector 5, count 1, dest 0x100 → 128 writes, first 0x03020100 at 0x100, last 0xFFFEFDFC at 0x2FC; `sd_cmd_o`=1 once with `sd_sector_o`=5; one `done_o`.
- count 3, sector 0xFFFFFFFF → reads sectors 0xFFFFFFFF, 0, 1; 384 writes, contiguous addresses.
- `mem_ready_i` random 30% duty → identical write sequence to ready-always run; no word dropped or duplicated; data/address stable while stalled.
- `sd_busy_i` held high 1000 cycles after reset, start issued → no `sd_cmd_o`≠0 until busy falls; then normal copy.
- count=0 → `done_o` pulse, zero `mem_write_o`, `sd_cmd_o` stays 0; `start_i` pulsed during a copy → ignored.
- `rst_ni` low mid-sector → all outputs at reset values within same cycle; fresh start afterwards completes correctly.
